// File: rtl/gfx_arb_pkg.sv
// Shared definitions for the frame-buffer memory arbiter.
// Holds the arbiter state encoding, requester indices, the read/write opcode
// values and small helpers used by the arbiter and its winner picker.
package gfx_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_DISP = 2'd0;
  localparam req_idx_t REQ_FILL = 2'd1;
  localparam req_idx_t REQ_LINE = 2'd2;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] req_onehot(input req_idx_t idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    case (idx)
      REQ_DISP: v[0] = 1'b1;
      REQ_FILL: v[1] = 1'b1;
      REQ_LINE: v[2] = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Burst counter width; a counter of at least one bit even for MAX_BURST = 1.
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/arb_winner_pick.sv
// Combinational winner selection for the frame-buffer arbiter.
// Ports:
//   rts       - ready-to-send from the three requesters
//   last_draw - drawing requester (1 or 2) that won the previous drawing grant
//   winner    - index of the requester that gets the next grant
//   valid     - at least one requester is asking
// Display (0) always wins; the two drawing engines alternate when both ask.
module arb_winner_pick
  import gfx_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] rts,
  input  req_idx_t           last_draw,
  output req_idx_t           winner,
  output logic               valid
);

  req_idx_t other_draw;

  assign other_draw = (last_draw == REQ_FILL) ? REQ_LINE : REQ_FILL;
  assign valid      = |rts;

  always_comb begin
    winner = REQ_DISP;
    if (rts[REQ_DISP]) begin
      winner = REQ_DISP;
    end else if (rts[REQ_FILL] && rts[REQ_LINE]) begin
      winner = other_draw;
    end else if (rts[REQ_FILL]) begin
      winner = REQ_FILL;
    end else if (rts[REQ_LINE]) begin
      winner = REQ_LINE;
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer memory arbiter.
// Shares one frame-buffer RAM port between display refresh (requester 0,
// fixed top priority) and the fill-rect / line drawing engines (requesters
// 1 and 2, round-robin), using the rts/rtr/xfc handshake.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_rts / req_rtr   - per-requester ready-to-send / grant
//   req_op              - per-requester 0 = write, 1 = read
//   req_wben            - 4 byte enables per requester
//   req_addr / req_data - packed per-requester address and write data
//   req_rdata           - shared read data (pass-through of mem_rdata)
//   req_rd_vld          - one-cycle pulse marking req_rdata for requester n
//   mem_*               - frame-buffer RAM port; mem_rdata valid 1 cycle after a read
//
// state    | meaning
// ARB_IDLE | no grant; picks a winner from req_rts for the next cycle
// ARB_OWN  | owner holds the port; transfers on every cycle its rts is set
module fb_mem_arbiter
  import gfx_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_rts,
  output logic [NUM_REQ-1:0]          req_rtr,
  input  logic [NUM_REQ-1:0]          req_op,
  input  logic [4*NUM_REQ-1:0]        req_wben,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [NUM_REQ-1:0]          req_rd_vld,
  output logic                        mem_en,
  output logic [3:0]                  mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int             CNT_W    = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t         state;
  req_idx_t           owner;
  req_idx_t           last_draw;
  logic [CNT_W-1:0]   burst_cnt;
  logic [NUM_REQ-1:0] rd_pend;

  req_idx_t           pick_idx;
  logic               pick_vld;

  logic               own_rts;
  logic               own_op;
  logic [3:0]         own_wben;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_data;

  logic               active;
  logic               xfc;
  logic               release_now;

  arb_winner_pick u_pick (
    .rts       (req_rts),
    .last_draw (last_draw),
    .winner    (pick_idx),
    .valid     (pick_vld)
  );

  // Owner's request lanes.
  always_comb begin
    own_rts  = 1'b0;
    own_op   = OP_WRITE;
    own_wben = '0;
    own_addr = '0;
    own_data = '0;
    case (owner)
      REQ_DISP: begin
        own_rts  = req_rts[0];
        own_op   = req_op[0];
        own_wben = req_wben[3:0];
        own_addr = req_addr[0*ADDR_W +: ADDR_W];
        own_data = req_data[0*DATA_W +: DATA_W];
      end
      REQ_FILL: begin
        own_rts  = req_rts[1];
        own_op   = req_op[1];
        own_wben = req_wben[7:4];
        own_addr = req_addr[1*ADDR_W +: ADDR_W];
        own_data = req_data[1*DATA_W +: DATA_W];
      end
      REQ_LINE: begin
        own_rts  = req_rts[2];
        own_op   = req_op[2];
        own_wben = req_wben[11:8];
        own_addr = req_addr[2*ADDR_W +: ADDR_W];
        own_data = req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        own_rts  = 1'b0;
      end
    endcase
  end

  // Outputs are held quiet while rst is high so a reset mid-burst never
  // leaks a strobe or grant in the reset cycle.
  assign active = (state == ARB_OWN) && !rst;
  assign xfc    = active && own_rts;

  assign req_rtr   = active ? req_onehot(owner) : '0;
  assign mem_en    = xfc;
  assign mem_we    = (xfc && (own_op == OP_WRITE)) ? own_wben : 4'h0;
  assign mem_addr  = xfc ? own_addr : '0;
  assign mem_wdata = xfc ? own_data : '0;

  assign req_rd_vld = rd_pend;
  assign req_rdata  = mem_rdata;

  // Display preemption releases even when the drawing owner transfers this
  // cycle; that transfer still completes because xfc is combinational.
  assign release_now = !own_rts
                    || (xfc && (burst_cnt == CNT_LAST))
                    || ((owner != REQ_DISP) && req_rts[REQ_DISP]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= REQ_DISP;
      last_draw <= REQ_LINE;
      burst_cnt <= '0;
      rd_pend   <= '0;
    end else begin
      rd_pend <= (xfc && (own_op == OP_READ)) ? req_onehot(owner) : '0;
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            state     <= ARB_OWN;
            owner     <= pick_idx;
            burst_cnt <= '0;
            if (pick_idx != REQ_DISP) begin
              last_draw <= pick_idx;
            end
          end
        end
        ARB_OWN: begin
          if (xfc) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (release_now) begin
            state <= ARB_IDLE;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a grant-level reference model.
module tb_fb_mem_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rts = '0;
  logic [2:0]  op = '0;
  logic [11:0] wben = '0;
  logic [47:0] addr = '0;
  logic [95:0] wdata_bus = '0;
  logic [2:0]  req_rtr;
  logic [31:0] req_rdata;
  logic [2:0]  req_rd_vld;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  fb_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_rts    (rts),
    .req_rtr    (req_rtr),
    .req_op     (op),
    .req_wben   (wben),
    .req_addr   (addr),
    .req_data   (wdata_bus),
    .req_rdata  (req_rdata),
    .req_rd_vld (req_rd_vld),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Frame-buffer RAM (256 words, read-before-write, 1-cycle read latency).
  bit [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: who holds the port (-1 = nobody), transfers so far in
  // this grant, last drawing winner, and the read return due next cycle.
  int          m_hold = -1;
  int          m_cnt = 0;
  int          m_last = 2;
  logic [2:0]  m_due = '0;
  logic [31:0] m_due_data = '0;
  bit [31:0]   shadow [256];

  bit          x_xfc;
  int          x_own;
  int          obs_xfc = 0;
  logic [2:0]  prev_rtr = '0;
  int          grant_log[$];
  int          rem [3];

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic check();
    logic [2:0]  e_rtr;
    logic [3:0]  e_we;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    bit          idle;
    e_rtr = '0; e_we = '0; e_addr = '0; e_data = '0;
    x_xfc = 0;
    x_own = m_hold;
    idle = rst || (m_hold < 0);
    if (!idle) begin
      e_rtr = 3'b001 << m_hold;
      x_xfc = rts[m_hold];
      if (x_xfc) begin
        e_we   = op[m_hold] ? 4'h0 : wben[4*m_hold +: 4];
        e_addr = addr[16*m_hold +: 16];
        e_data = wdata_bus[32*m_hold +: 32];
      end
    end
    cmp("rtr", {29'd0, req_rtr}, {29'd0, e_rtr});
    cmp("mem_en", {31'd0, mem_en}, {31'd0, x_xfc});
    if (x_xfc || idle) begin
      cmp("mem_we", {28'd0, mem_we}, {28'd0, e_we});
      cmp("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
      cmp("mem_wdata", mem_wdata, e_data);
    end
    cmp("rd_vld", {29'd0, req_rd_vld}, {29'd0, m_due});
    if (m_due != 0) cmp("rdata", req_rdata, m_due_data);
    if (mem_en) obs_xfc++;
    if (req_rtr != 0 && req_rtr != prev_rtr)
      grant_log.push_back(req_rtr[2] ? 2 : (req_rtr[1] ? 1 : 0));
    prev_rtr = req_rtr;
  endtask

  task automatic model_update();
    int a;
    int pref;
    if (rst) begin
      m_hold = -1; m_cnt = 0; m_last = 2; m_due = '0;
    end else begin
      m_due = '0;
      if (x_xfc) begin
        a = int'(addr[16*m_hold +: 8]);
        if (op[m_hold]) begin
          m_due = 3'b001 << m_hold;
          m_due_data = shadow[a];
        end else begin
          for (int b = 0; b < 4; b++)
            if (wben[4*m_hold + b]) shadow[a][8*b +: 8] = wdata_bus[32*m_hold + 8*b +: 8];
        end
      end
      if (m_hold < 0) begin
        if (rts != 0) begin
          pref = 3 - m_last;
          if (rts[0]) m_hold = 0;
          else if (rts[pref]) m_hold = pref;
          else m_hold = m_last;
          if (m_hold != 0) m_last = m_hold;
          m_cnt = 0;
        end
      end else begin
        if (x_xfc) m_cnt++;
        if (!rts[m_hold] || (x_xfc && m_cnt == MB) || (m_hold != 0 && rts[0]))
          m_hold = -1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Engine behaviour: hold rts while work remains, advance address per transfer.
  task automatic step();
    for (int n = 0; n < 3; n++) rts[n] = (rem[n] > 0);
    cycle();
    if (x_xfc) begin
      rem[x_own]--;
      addr[16*x_own +: 16] = addr[16*x_own +: 16] + 16'd1;
      wdata_bus[32*x_own +: 32] = $urandom;
    end
  endtask

  task automatic run(input int budget);
    int k;
    k = 0;
    while ((rem[0] + rem[1] + rem[2]) > 0 && k < budget) begin
      step();
      k++;
    end
    cmp("run_done", 32'(rem[0] + rem[1] + rem[2]), 32'd0);
    rts = '0;
    cycle();
    cycle();
  endtask

  initial begin
    int k;
    rem[0] = 0; rem[1] = 0; rem[2] = 0;
    wdata_bus = {$urandom, $urandom, $urandom};

    // Reset state.
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Single writer: requester 1, four full-word writes at 0x0010..0x0013.
    op = 3'b000; wben = 12'h0F0; addr[31:16] = 16'h0010;
    obs_xfc = 0;
    rem[1] = 4;
    step();
    cmp("grant_latency", {29'd0, req_rtr}, 32'h2);
    run(20);
    cmp("single_xfc_cnt", 32'(obs_xfc), 32'd4);

    // Burst cap: ten transfers from requester 2 split 4/4/2.
    wben = 12'h5F0; addr[47:32] = 16'h0040;
    obs_xfc = 0; grant_log.delete();
    rem[2] = 10;
    run(40);
    cmp("burst_xfc_cnt", 32'(obs_xfc), 32'd10);
    cmp("burst_grants", 32'(grant_log.size()), 32'd3);

    // Round-robin: both drawing engines busy; requester 1 goes first.
    grant_log.delete();
    rem[1] = 8; rem[2] = 8;
    run(60);
    cmp("rr_grants", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      cmp("rr_owner", 32'(grant_log[i]), 32'((i % 2) + 1));

    // Preemption of requester 1 by display.
    rem[1] = 8;
    k = 0;
    while (rem[1] > 6 && k < 20) begin step(); k++; end
    rem[0] = 1; wben[3:0] = 4'hF; addr[15:0] = 16'h0080;
    step();
    cmp("preempt_idle", {29'd0, req_rtr}, 32'h0);
    step();
    cmp("preempt_grant", {29'd0, req_rtr}, 32'h1);
    run(40);

    // Read path: display writes 0xDEADBEEF at 0x0100 then reads it back.
    op[0] = 1'b0; addr[15:0] = 16'h0100; wdata_bus[31:0] = 32'hDEADBEEF;
    rem[0] = 1;
    run(10);
    op[0] = 1'b1; addr[15:0] = 16'h0100;
    rem[0] = 1;
    k = 0;
    x_xfc = 0;
    while (!x_xfc && k < 10) begin step(); k++; end
    cmp("read_vld", {29'd0, req_rd_vld}, 32'h1);
    cmp("read_data", req_rdata, 32'hDEADBEEF);
    rts = '0;
    cycle();
    op[0] = 1'b0;

    // Reset mid-burst from requester 2, then a 1/2 tie goes to requester 1.
    rem[2] = 8;
    k = 0;
    while (rem[2] > 6 && k < 20) begin step(); k++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp("rst_rtr", {29'd0, req_rtr}, 32'h0);
    cmp("rst_mem_en", {31'd0, mem_en}, 32'h0);
    rem[1] = 2; rem[2] = 2;
    step();
    cmp("rst_tie_winner", {29'd0, req_rtr}, 32'h2);
    run(30);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 3; n++) begin
        rts[n] = ($urandom_range(0, 3) != 0);
        addr[16*n +: 16] = 16'($urandom_range(0, 255));
      end
      op = 3'($urandom);
      wben = 12'($urandom);
      wdata_bus = {$urandom, $urandom, $urandom};
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    rts = '0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_mem_arbiter.md
# fb_mem_arbiter

Frame-buffer memory arbiter: shares the single 16-bit-address, 32-bit-data frame-buffer port between three requesters using the rts/rtr/xfc handshake of the data-gen engines. Requester 0 is display refresh (fixed highest priority). Requesters 1 and 2 are drawing engines, fill-rect data gen and line data gen, and alternate round-robin. Sits between the engines' arbiter output interfaces and the frame-buffer RAM.

## Interface
- ADDR_W, 16, address width
- DATA_W, 32, data width
- MAX_BURST, 16, max transfers per grant before forced re-arbitration (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_rts  in  3  requester n ready-to-send
- req_rtr  out  3  requester n ready-to-receive (grant)
- req_op  in  3  per requester: 0 = write, 1 = read
- req_wben  in  12  4 byte enables per requester, requester n at [4n+3:4n]
- req_addr  in  3×ADDR_W  requester n at [ADDR_W·n +: ADDR_W]
- req_data  in  3×DATA_W  write data, same packing
- req_rdata  out  DATA_W  read data, shared by all requesters
- req_rd_vld  out  3  one-cycle pulse: req_rdata valid for requester n
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte write enables (0 on read)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid 1 cycle after a read strobe

## Operation
- States: IDLE, OWN. Registers: owner[1:0], burst_cnt (clog2(MAX_BURST) bits), last_draw (1 or 2), rd_pend[2:0].
- IDLE: if any req_rts is set, pick the winner and go to OWN with owner = winner and burst_cnt = 0. Winner priority: req 0 if rts[0]; else the drawing requester ≠ last_draw if its rts is set; else the other drawing requester. On a drawing win, last_draw ← winner.
- OWN: req_rtr[owner] = 1, all others 0. xfc = req_rts[owner] & req_rtr[owner].
- On xfc: mem_en = 1, mem_addr/mem_wdata from owner, mem_we = op ? 4'h0 : wben[owner]. burst_cnt increments.
- OWN → IDLE at the clock edge when any of these holds:
  - (a) !req_rts[owner]
  - (b) xfc and burst_cnt == MAX_BURST-1
  - (c) owner ≠ 0 and req_rts[0]. Display preempts; the transfer in progress this cycle still completes.
- Read return: a read xfc sets rd_pend[owner] for one cycle. req_rd_vld = rd_pend. req_rdata = mem_rdata (combinational pass-through).
- Writes with wben = 0 still pulse mem_en with mem_we = 0. This is legal.

## Timing
- Reset values: state IDLE, req_rtr 0, req_rd_vld 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, burst_cnt 0, last_draw = 2 (requester 1 wins the first drawing tie), owner 0.
- mem_* and req_rtr are combinational from state/owner/inputs. They must be 0 in IDLE and in reset.
- Grant latency: rts rising in IDLE gives rtr in the next cycle. One dead IDLE cycle follows every release.
- Back-to-back xfc every cycle while owned. Max burst is MAX_BURST transfers.
- Read latency: read xfc in cycle t gives req_rd_vld[n] and valid rdata in cycle t+1, even if ownership was released at t.
- Display worst-case wait: 1 cycle of current transfer + 1 IDLE cycle = grant 2 cycles after rts[0] asserts.
- Reset mid-burst: next cycle is IDLE with rtr 0, rd_pend cleared, and no mem_en. An in-flight read's vld is dropped.
- Simultaneous rts[1] and rts[2] in IDLE: strict alternation via last_draw.

## Structure
- Package gfx_arb_pkg:
  - state encoding (ARB_IDLE, ARB_OWN)
  - requester indices (REQ_DISP = 0, REQ_FILL = 1, REQ_LINE = 2)
  - OP_WRITE = 0, OP_READ = 1
  - NUM_REQ = 3
- One sub-module, arb_winner_pick: combinational. Inputs rts[2:0] and last_draw; outputs winner index and valid.
- Remainder is muxing, burst counter and state register.

## Test plan
- Single writer: rts[1] held for 4 writes, wben 4'hF, addr 0x0010..0x0013 → rtr[1] from cycle 2, mem_we = F each cycle, release after rts drops, one IDLE cycle.
- Burst cap: MAX_BURST = 4, rts[2] held for 10 transfers → grants of 4, 4, 2 transfers, each separated by one IDLE cycle.
- Round-robin: rts[1] and rts[2] held continuously, MAX_BURST = 2 → owner sequence 1, 2, 1, 2 starting with 1 after reset.
- Preemption: requester 1 mid-burst, rts[0] asserted at cycle t → transfer at t completes, IDLE at t+1, rtr[0] at t+2.
- Read path: requester 0 reads 0x0100, model returns 0xDEADBEEF → req_rd_vld = 3'b001 with rdata 0xDEADBEEF exactly one cycle after xfc. mem_we = 0.
- Reset mid-burst: rst pulsed during requester 2 writes → next cycle mem_en = 0 and rtr = 0. After release, requester 1 wins a 1/2 tie.
